// File: rtl/rom_download_sequencer.sv
// ROM-download transmitter: writes the host image into the core ROM port,
// zero-fills the unsent tail and keeps the core in reset until the image is whole.
module rom_download_sequencer #(
  parameter logic [16:0] IMG_SIZE    = 17'h13600,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  MODEL_INDEX = 8'd1,
  parameter int unsigned WR_CYCLES   = 2,
  parameter logic [15:0] RST_HOLD    = 16'd1024
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        DL_ACTIVE,
  input  logic        DL_WR,
  input  logic [7:0]  DL_INDEX,
  input  logic [24:0] DL_ADDR,
  input  logic [7:0]  DL_DATA,
  output logic        DL_WAIT,
  output logic [16:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic [2:0]  MODEL,
  output logic        CORE_RESET,
  output logic        DL_ERR
);

  localparam logic [2:0]  WR_LAST   = 3'(WR_CYCLES - 1);
  localparam logic [17:0] IMG_END   = {1'b0, IMG_SIZE};
  localparam logic [24:0] ADDR_END  = {8'd0, IMG_SIZE};
  localparam logic [15:0] HOLD_LAST = RST_HOLD - 16'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_FILL   = 3'd3,
    ST_FWRITE = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [16:0] romad_r, romad_s;
  logic [7:0]  romdt_r, romdt_s;
  logic        romen_r, romen_s;
  logic        dl_wait_r, dl_wait_s;
  logic [2:0]  model_r, model_s;
  logic        core_reset_r, core_reset_s;
  logic        dl_err_r, dl_err_s;
  logic [2:0]  wr_cnt_r, wr_cnt_s;
  logic [17:0] hwm_r, hwm_s;
  logic [15:0] hold_cnt_r, hold_cnt_s;
  logic        dl_active_q_r;

  logic        rom_idx_s;
  logic        rom_start_s;
  logic        accept_s;
  logic        in_range_s;
  logic        pulse_last_s;
  logic        model_wr_s;
  logic        in_tail_s;
  logic        enter_load_s;
  logic [17:0] wr_next_s;

  assign rom_idx_s    = (DL_INDEX == ROM_INDEX);
  assign rom_start_s  = DL_ACTIVE && !dl_active_q_r && rom_idx_s;
  assign accept_s     = DL_WR && !dl_wait_r && rom_idx_s;
  assign in_range_s   = (DL_ADDR < ADDR_END);
  assign pulse_last_s = (wr_cnt_r == WR_LAST);
  assign model_wr_s   = DL_WR && (DL_INDEX == MODEL_INDEX) && (DL_ADDR == 25'd0);
  assign in_tail_s    = (state_r == ST_FILL) || (state_r == ST_FWRITE) || (state_r == ST_HOLD);
  // A fresh ROM download restarts from scratch, even while filling or holding.
  assign enter_load_s = (state_r == ST_IDLE) ? (DL_ACTIVE && rom_idx_s) : (in_tail_s && rom_start_s);
  // Widened by one bit so the high-water mark cannot wrap at the top address.
  assign wr_next_s    = {1'b0, romad_r} + 18'd1;

  // State register.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    if (enter_load_s) begin
      state_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (accept_s && in_range_s) begin
            state_s = ST_WRITE;
          end else if (!DL_ACTIVE && !accept_s) begin
            state_s = ST_FILL;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_WRITE: begin
          if (!pulse_last_s) begin
            state_s = ST_WRITE;
          end else if (DL_ACTIVE) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_FILL;
          end
        end
        ST_FILL: begin
          if (hwm_r < IMG_END) begin
            state_s = ST_FWRITE;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_FWRITE: begin
          if (!pulse_last_s) begin
            state_s = ST_FWRITE;
          end else if ((hwm_r + 18'd1) < IMG_END) begin
            state_s = ST_FILL;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    romad_s      = romad_r;
    romdt_s      = romdt_r;
    romen_s      = romen_r;
    dl_wait_s    = dl_wait_r;
    core_reset_s = core_reset_r;
    dl_err_s     = dl_err_r;
    wr_cnt_s     = wr_cnt_r;
    hwm_s        = hwm_r;
    hold_cnt_s   = hold_cnt_r;
    if (model_wr_s) begin
      model_s = DL_DATA[2:0];
    end else begin
      model_s = model_r;
    end
    if (enter_load_s) begin
      romen_s      = 1'b0;
      dl_wait_s    = 1'b0;
      core_reset_s = 1'b1;
      dl_err_s     = 1'b0;
      hwm_s        = 18'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (accept_s && in_range_s) begin
            romad_s   = DL_ADDR[16:0];
            romdt_s   = DL_DATA;
            romen_s   = 1'b1;
            dl_wait_s = 1'b1;
            wr_cnt_s  = 3'd0;
          end else if (accept_s) begin
            dl_err_s = 1'b1;
          end else begin
            dl_err_s = dl_err_r;
          end
        end
        // Host and fill pulses share the same timing and high-water update.
        ST_WRITE, ST_FWRITE: begin
          if (pulse_last_s) begin
            romen_s    = 1'b0;
            dl_wait_s  = 1'b0;
            hold_cnt_s = 16'd0;
            if (wr_next_s > hwm_r) begin
              hwm_s = wr_next_s;
            end else begin
              hwm_s = hwm_r;
            end
          end else begin
            wr_cnt_s = wr_cnt_r + 3'd1;
          end
        end
        ST_FILL: begin
          if (hwm_r < IMG_END) begin
            romad_s  = hwm_r[16:0];
            romdt_s  = 8'd0;
            romen_s  = 1'b1;
            wr_cnt_s = 3'd0;
          end else begin
            hold_cnt_s = 16'd0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            core_reset_s = 1'b0;
          end else begin
            hold_cnt_s = hold_cnt_r + 16'd1;
          end
        end
        default: core_reset_s = core_reset_r;
      endcase
    end
  end

  // Output and datapath registers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      romad_r       <= 17'd0;
      romdt_r       <= 8'd0;
      romen_r       <= 1'b0;
      dl_wait_r     <= 1'b0;
      model_r       <= 3'd0;
      core_reset_r  <= 1'b1;
      dl_err_r      <= 1'b0;
      wr_cnt_r      <= 3'd0;
      hwm_r         <= 18'd0;
      hold_cnt_r    <= 16'd0;
      dl_active_q_r <= 1'b0;
    end else begin
      romad_r       <= romad_s;
      romdt_r       <= romdt_s;
      romen_r       <= romen_s;
      dl_wait_r     <= dl_wait_s;
      model_r       <= model_s;
      core_reset_r  <= core_reset_s;
      dl_err_r      <= dl_err_s;
      wr_cnt_r      <= wr_cnt_s;
      hwm_r         <= hwm_s;
      hold_cnt_r    <= hold_cnt_s;
      dl_active_q_r <= DL_ACTIVE;
    end
  end

  assign DL_WAIT    = dl_wait_r;
  assign ROMAD      = romad_r;
  assign ROMDT      = romdt_r;
  assign ROMEN      = romen_r;
  assign MODEL      = model_r;
  assign CORE_RESET = core_reset_r;
  assign DL_ERR     = dl_err_r;

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Bench for rom_download_sequencer: random host downloads checked against an
// expected write list (host bytes in order, then zeros from the high-water mark).
module tb_rom_download_sequencer;

  localparam logic [16:0] IMG  = 17'd8;
  localparam int          WRC  = 2;
  localparam logic [15:0] HOLD = 16'd20;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DL_ACTIVE = 1'b0;
  logic        DL_WR = 1'b0;
  logic [7:0]  DL_INDEX = 8'd0;
  logic [24:0] DL_ADDR = 25'd0;
  logic [7:0]  DL_DATA = 8'd0;
  logic        DL_WAIT;
  logic [16:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        ROMEN;
  logic [2:0]  MODEL;
  logic        CORE_RESET;
  logic        DL_ERR;

  rom_download_sequencer #(
    .IMG_SIZE(IMG), .ROM_INDEX(8'd0), .MODEL_INDEX(8'd1),
    .WR_CYCLES(WRC), .RST_HOLD(HOLD)
  ) dut (
    .MCLK(MCLK), .RESET(RESET), .DL_ACTIVE(DL_ACTIVE), .DL_WR(DL_WR),
    .DL_INDEX(DL_INDEX), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA),
    .DL_WAIT(DL_WAIT), .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN),
    .MODEL(MODEL), .CORE_RESET(CORE_RESET), .DL_ERR(DL_ERR)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
    int          len;
    logic        w;
    int          fall;
  } wr_t;

  wr_t  wq[$];
  wr_t  cur;
  int   cyc = 0;
  int   cr_fall = 0;
  logic prev_en = 1'b0;
  logic prev_cr = 1'b1;
  logic unstable = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          host_a[$];
  logic [7:0]  host_d[$];
  logic [2:0]  exp_model = 3'd0;

  // Records every ROMEN pulse observed on the falling clock edge.
  always @(negedge MCLK) begin
    cyc <= cyc + 1;
    if (ROMEN && !prev_en) begin
      cur.a   <= ROMAD;
      cur.d   <= ROMDT;
      cur.len <= 1;
      cur.w   <= DL_WAIT;
    end else if (ROMEN) begin
      cur.len <= cur.len + 1;
      cur.w   <= cur.w & DL_WAIT;
      if (ROMAD !== cur.a || ROMDT !== cur.d) unstable <= 1'b1;
    end else if (prev_en) begin
      wq.push_back('{a: cur.a, d: cur.d, len: cur.len, w: cur.w, fall: cyc});
    end
    if (prev_cr && !CORE_RESET) cr_fall <= cyc;
    prev_en <= ROMEN;
    prev_cr <= CORE_RESET;
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                           input bit rogue, input bit drop, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (DL_WAIT === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge MCLK);
    end
    if (ok) begin
      DL_ADDR = a;
      DL_DATA = d;
      DL_WR   = 1'b1;
      @(negedge MCLK);
      DL_WR = 1'b0;
      if (drop) DL_ACTIVE = 1'b0;
      if (rogue) begin
        DL_ADDR = 25'(IMG) - 25'd1;
        DL_DATA = ~d;
        DL_WR   = 1'b1;
        @(negedge MCLK);
        DL_WR = 1'b0;
      end
    end
  endtask

  task automatic wait_idle_host();
    for (int k = 0; k < 50; k++) begin
      if (DL_WAIT === 1'b0) break;
      @(negedge MCLK);
    end
  endtask

  task automatic wait_core_release(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (CORE_RESET === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge MCLK);
    end
    @(negedge MCLK);
  endtask

  task automatic gen_random();
    int c, n;
    host_a.delete();
    host_d.delete();
    c = $urandom_range(0, 1);
    n = $urandom_range(1, 5);
    while (c <= int'(IMG) - 2 && host_a.size() < n) begin
      host_a.push_back(c);
      host_d.push_back(8'($urandom));
      c += $urandom_range(1, 2);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge MCLK);
    checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %0h expected 1", CORE_RESET); end
    checks++; if (ROMEN !== 1'b0) begin errors++; $display("FAIL reset_romen: got %0h expected 0", ROMEN); end
    checks++; if (MODEL !== 3'd0) begin errors++; $display("FAIL reset_model: got %0h expected 0", MODEL); end
    checks++; if ({DL_WAIT, DL_ERR, ROMAD, ROMDT} !== 27'd0) begin errors++; $display("FAIL reset_misc: got %0h expected 0", {DL_WAIT, DL_ERR, ROMAD, ROMDT}); end
    RESET = 1'b0;
    repeat (50) @(negedge MCLK);
    checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL reset_held: got %0h expected 1", CORE_RESET); end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL reset_no_write: got %0d expected 0", wq.size()); end
  endtask

  task automatic test_model();
    logic [7:0] d;
    int base;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'h05 : 8'($urandom);
      base = wq.size();
      DL_INDEX = 8'd1;
      DL_ADDR  = 25'd0;
      DL_DATA  = d;
      DL_WR    = 1'b1;
      @(negedge MCLK);
      DL_WR = 1'b0;
      exp_model = d[2:0];
      checks++; if (MODEL !== exp_model) begin errors++; $display("FAIL model_latch: got %0h expected %0h", MODEL, exp_model); end
      DL_ADDR = 25'($urandom_range(1, 1000));
      DL_DATA = ~d;
      DL_WR   = 1'b1;
      @(negedge MCLK);
      DL_WR = 1'b0;
      @(negedge MCLK);
      checks++; if (MODEL !== exp_model) begin errors++; $display("FAIL model_other_addr: got %0h expected %0h", MODEL, exp_model); end
      checks++; if (wq.size() != base || ROMEN !== 1'b0) begin errors++; $display("FAIL model_no_romen: got %0d writes expected 0", wq.size() - base); end
    end
    DL_INDEX = 8'd0;
  endtask

  task automatic test_download(input bit rogue, input bit late_drop);
    int base, hwm, nh;
    logic [16:0] ea[$];
    logic [7:0]  ed[$];
    bit ok;
    base = wq.size();
    nh = host_a.size();
    DL_INDEX  = 8'd0;
    DL_ACTIVE = 1'b1;
    @(negedge MCLK);
    checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL dl_start_core_reset: got %0h expected 1", CORE_RESET); end
    checks++; if (DL_ERR !== 1'b0) begin errors++; $display("FAIL dl_start_err: got %0h expected 0", DL_ERR); end
    for (int i = 0; i < nh; i++) begin
      send_byte(25'(host_a[i]), host_d[i], rogue, late_drop && (i == nh - 1), ok);
      checks++; if (!ok) begin errors++; $display("FAIL host_wait_timeout: got DL_WAIT stuck expected release"); end
      ea.push_back(17'(host_a[i]));
      ed.push_back(host_d[i]);
    end
    hwm = host_a[nh - 1] + 1;
    for (int f = hwm; f < int'(IMG); f++) begin
      ea.push_back(17'(f));
      ed.push_back(8'd0);
    end
    if (!late_drop) begin
      wait_idle_host();
      DL_ACTIVE = 1'b0;
    end
    wait_core_release(ok);
    checks++; if (!ok) begin errors++; $display("FAIL dl_release_timeout: got CORE_RESET=%0h expected 0", CORE_RESET); end
    checks++; if (wq.size() - base != ea.size()) begin errors++; $display("FAIL dl_write_count: got %0d expected %0d", wq.size() - base, ea.size()); end
    for (int i = 0; i < ea.size() && base + i < wq.size(); i++) begin
      checks++; if (wq[base + i].a !== ea[i]) begin errors++; $display("FAIL dl_addr[%0d]: got %0h expected %0h", i, wq[base + i].a, ea[i]); end
      checks++; if (wq[base + i].d !== ed[i]) begin errors++; $display("FAIL dl_data[%0d]: got %0h expected %0h", i, wq[base + i].d, ed[i]); end
      checks++; if (wq[base + i].len != WRC) begin errors++; $display("FAIL dl_pulse_len[%0d]: got %0d expected %0d", i, wq[base + i].len, WRC); end
      if (i < nh) begin
        checks++; if (wq[base + i].w !== 1'b1) begin errors++; $display("FAIL dl_wait_during_write[%0d]: got %0h expected 1", i, wq[base + i].w); end
      end
    end
    if (wq.size() > base) begin
      checks++; if (cr_fall - wq[wq.size() - 1].fall != int'(HOLD)) begin errors++; $display("FAIL dl_hold_time: got %0d expected %0d", cr_fall - wq[wq.size() - 1].fall, HOLD); end
    end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL dl_addr_data_stable: got unstable expected stable"); end
  endtask

  task automatic test_out_of_range();
    int base;
    bit ok;
    base = wq.size();
    DL_INDEX  = 8'd0;
    DL_ACTIVE = 1'b1;
    @(negedge MCLK);
    send_byte(25'(IMG), 8'h5A, 1'b0, 1'b0, ok);
    checks++; if (DL_ERR !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %0h expected 1", DL_ERR); end
    send_byte(25'h20000 + 25'($urandom_range(0, 7)), 8'hA5, 1'b0, 1'b0, ok);
    repeat (3) @(negedge MCLK);
    checks++; if (wq.size() != base || ROMEN !== 1'b0) begin errors++; $display("FAIL oor_no_write: got %0d writes expected 0", wq.size() - base); end
    DL_ACTIVE = 1'b0;
    wait_core_release(ok);
    checks++; if (!ok) begin errors++; $display("FAIL oor_release_timeout: got CORE_RESET=%0h expected 0", CORE_RESET); end
    checks++; if (wq.size() - base != int'(IMG)) begin errors++; $display("FAIL oor_fill_count: got %0d expected %0d", wq.size() - base, IMG); end
    for (int i = 0; i < int'(IMG) && base + i < wq.size(); i++) begin
      checks++; if (wq[base + i].a !== 17'(i) || wq[base + i].d !== 8'd0) begin errors++; $display("FAIL oor_fill[%0d]: got %0h/%0h expected %0h/0", i, wq[base + i].a, wq[base + i].d, i); end
    end
    checks++; if (DL_ERR !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %0h expected 1", DL_ERR); end
    DL_ACTIVE = 1'b1;
    @(negedge MCLK);
    checks++; if (DL_ERR !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %0h expected 0", DL_ERR); end
    DL_ACTIVE = 1'b0;
    wait_core_release(ok);
    checks++; if (!ok) begin errors++; $display("FAIL oor_second_release_timeout: got CORE_RESET=%0h expected 0", CORE_RESET); end
  endtask

  task automatic test_reset_mid_fill();
    int n0;
    bit ok, seen;
    DL_INDEX  = 8'd0;
    DL_ACTIVE = 1'b1;
    @(negedge MCLK);
    n0 = wq.size();
    send_byte(25'd0, 8'h3C, 1'b0, 1'b0, ok);
    wait_idle_host();
    DL_ACTIVE = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge MCLK);
      if (wq.size() >= n0 + 2 && ROMEN === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midfill_reach_timeout: got no fill pulse expected one"); end
    RESET = 1'b1;
    #1;
    checks++; if (ROMEN !== 1'b0) begin errors++; $display("FAIL midfill_romen: got %0h expected 0", ROMEN); end
    checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL midfill_core_reset: got %0h expected 1", CORE_RESET); end
    repeat (2) @(negedge MCLK);
    n0 = wq.size();
    RESET = 1'b0;
    repeat (int'(HOLD) + 30) @(negedge MCLK);
    checks++; if (wq.size() != n0) begin errors++; $display("FAIL midfill_no_more_writes: got %0d expected %0d", wq.size(), n0); end
    checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL midfill_core_held: got %0h expected 1", CORE_RESET); end
    exp_model = 3'd0;
    checks++; if (MODEL !== exp_model || DL_WAIT !== 1'b0) begin errors++; $display("FAIL midfill_model_wait: got %0h/%0h expected 0/0", MODEL, DL_WAIT); end
  endtask

  initial begin
    test_reset();
    test_model();
    host_a = '{0, 1, 2, 3};
    host_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    test_download(1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      gen_random();
      test_download(r[0], 1'b0);
    end
    gen_random();
    test_download(1'b0, 1'b1);
    test_out_of_range();
    test_reset_mid_fill();
    gen_random();
    test_download(1'b1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
